// File: rtl/prog_loader.sv
// prog_loader: fills a 16x8 program RAM from a valid/ready byte stream, then checks
// a trailing checksum byte. Holds the CPU while a load is in progress.
// Ports:
//   clk, rst (sync, active-low)
//   start                      one-cycle load request (honoured in IDLE/DONE only)
//   in_data/in_valid/in_ready  byte stream handshake
//   rd_addr/rd_data            asynchronous CPU fetch port
//   cpu_hold                   CPU must not advance while high
//   done/err                   load finished / checksum mismatch on last load
module prog_loader #(
    parameter int unsigned AW = 4,
    parameter int unsigned DW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [DW-1:0] in_data,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [AW-1:0] rd_addr,
    output logic [DW-1:0] rd_data,
    output logic          cpu_hold,
    output logic          done,
    output logic          err
);

    localparam int unsigned DEPTH = 2 ** AW;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        CHECK = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t        state, state_n;
    logic [AW-1:0] addr, addr_n;
    logic [DW-1:0] sum, sum_n;
    logic          done_n, err_n;
    logic          xfer_c;
    logic          we_c;
    logic [DW-1:0] chk_c;

    logic [DW-1:0] mem [DEPTH];

    // in_ready is a flop, so the handshake never depends combinationally on inputs
    assign xfer_c = in_valid && in_ready;
    assign chk_c  = sum + in_data;

    // Next-state and datapath updates
    always_comb begin
        state_n = state;
        addr_n  = addr;
        sum_n   = sum;
        done_n  = done;
        err_n   = err;
        we_c    = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    state_n = LOAD;
                    addr_n  = '0;
                    sum_n   = '0;
                    done_n  = 1'b0;
                    err_n   = 1'b0;
                end
            end
            LOAD: begin
                if (xfer_c) begin
                    // Reset wins over a coincident write
                    we_c   = rst;
                    sum_n  = chk_c;
                    addr_n = addr + AW'(1);
                    if (addr == AW'(DEPTH - 1)) begin
                        state_n = CHECK;
                    end
                end
            end
            CHECK: begin
                if (xfer_c) begin
                    err_n   = (chk_c != '0);
                    done_n  = 1'b1;
                    state_n = DONE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // State register; in_ready/cpu_hold are registered decodes of the next state
    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= IDLE;
            addr     <= '0;
            sum      <= '0;
            done     <= 1'b0;
            err      <= 1'b0;
            in_ready <= 1'b0;
            cpu_hold <= 1'b0;
        end else begin
            state    <= state_n;
            addr     <= addr_n;
            sum      <= sum_n;
            done     <= done_n;
            err      <= err_n;
            in_ready <= (state_n == LOAD) || (state_n == CHECK);
            cpu_hold <= (state_n == LOAD) || (state_n == CHECK);
        end
    end

    // Program RAM: not cleared by reset
    always_ff @(posedge clk) begin
        if (we_c) begin
            mem[addr] <= in_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: tb/tb_prog_loader.sv
module tb_prog_loader;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] rd_addr;
    logic [7:0] rd_data;
    logic       cpu_hold;
    logic       done;
    logic       err;

    int checks = 0;
    int errors = 0;

    logic [7:0] stim [16];
    logic [7:0] ck;
    logic [7:0] model_mem [16];
    logic       model_known [16];

    prog_loader #(.AW(4), .DW(8)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .cpu_hold (cpu_hold),
        .done     (done),
        .err      (err)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Run a full load of stim[] + ck. mode: 0 always valid, 1 toggle, 2 random.
    // start_at >= 0 pulses start at that byte index; coincide drives valid with start.
    task automatic run_load(input int mode, input int start_at, input bit coincide);
        int idx = 0;
        int cyc = 0;
        bit tog = 1'b1;
        bit v;
        int total;
        logic [7:0] exp_err;
        start    = 1'b1;
        in_valid = coincide;
        in_data  = 8'hEE;
        step();
        start    = 1'b0;
        in_valid = 1'b0;
        checks++;
        if (done !== 1'b0 || err !== 1'b0 || in_ready !== 1'b1 || cpu_hold !== 1'b1) begin
            errors++;
            $display("FAIL after_start: done=%b err=%b in_ready=%b cpu_hold=%b want 0 0 1 1",
                     done, err, in_ready, cpu_hold);
        end
        while (idx < 17 && cyc < 300) begin
            case (mode)
                0:       v = 1'b1;
                1:       v = tog;
                default: v = 1'($urandom_range(0, 1));
            endcase
            tog      = ~tog;
            in_valid = v;
            in_data  = (idx < 16) ? stim[idx] : ck;
            start    = (idx == start_at);
            checks++;
            if (in_ready !== 1'b1 || cpu_hold !== 1'b1 || done !== 1'b0) begin
                errors++;
                $display("FAIL loading idx=%0d: in_ready=%b cpu_hold=%b done=%b want 1 1 0",
                         idx, in_ready, cpu_hold, done);
            end
            step();
            start = 1'b0;
            if (v) begin
                if (idx < 16) begin
                    model_mem[idx]   = stim[idx];
                    model_known[idx] = 1'b1;
                    rd_addr = 4'(idx);
                    #1;
                    checks++;
                    if (rd_data !== stim[idx]) begin
                        errors++;
                        $display("FAIL write_visible addr=%0d: got %h want %h",
                                 idx, rd_data, stim[idx]);
                    end
                end
                idx++;
            end
            cyc++;
        end
        in_valid = 1'b0;
        checks++;
        if (idx != 17) begin
            errors++;
            $display("FAIL load_timeout: transfers=%0d want 17", idx);
        end
        total = 0;
        for (int i = 0; i < 16; i++) total += stim[i];
        total += ck;
        exp_err = ((total % 256) != 0) ? 8'd1 : 8'd0;
        checks++;
        if (done !== 1'b1 || err !== exp_err[0] || cpu_hold !== 1'b0 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL load_result: done=%b err=%b cpu_hold=%b in_ready=%b want 1 %b 0 0",
                     done, err, cpu_hold, in_ready, exp_err[0]);
        end
        // Extra valid cycles in DONE must not be consumed
        in_valid = 1'b1;
        in_data  = 8'h5A;
        step();
        step();
        in_valid = 1'b0;
        checks++;
        if (done !== 1'b1 || err !== exp_err[0] || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL done_hold: done=%b err=%b in_ready=%b want 1 %b 0",
                     done, err, in_ready, exp_err[0]);
        end
    endtask

    task automatic check_ram(input string tag);
        for (int a = 0; a < 16; a++) begin
            if (model_known[a]) begin
                rd_addr = 4'(a);
                #1;
                checks++;
                if (rd_data !== model_mem[a]) begin
                    errors++;
                    $display("FAIL %s ram[%0d]: got %h want %h", tag, a, rd_data, model_mem[a]);
                end
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        step();
        step();
        rst = 1'b1;
        checks++;
        if (in_ready !== 1'b0 || cpu_hold !== 1'b0 || done !== 1'b0 || err !== 1'b0) begin
            errors++;
            $display("FAIL reset: in_ready=%b cpu_hold=%b done=%b err=%b want 0 0 0 0",
                     in_ready, cpu_hold, done, err);
        end
        // start is the only way out of IDLE
        in_valid = 1'b1;
        in_data  = 8'h33;
        step();
        in_valid = 1'b0;
        checks++;
        if (in_ready !== 1'b0 || cpu_hold !== 1'b0) begin
            errors++;
            $display("FAIL idle_stays: in_ready=%b cpu_hold=%b want 0 0", in_ready, cpu_hold);
        end
    endtask

    task automatic set_counting();
        for (int i = 0; i < 16; i++) stim[i] = 8'(8'h10 + i);
    endtask

    task automatic test_good_load();
        set_counting();
        ck = 8'h88;
        run_load(0, -1, 1'b0);
        rd_addr = 4'd5;
        #1;
        checks++;
        if (rd_data !== 8'h15) begin
            errors++;
            $display("FAIL good_rd5: got %h want 15", rd_data);
        end
        rd_addr = 4'd15;
        #1;
        checks++;
        if (rd_data !== 8'h1F) begin
            errors++;
            $display("FAIL good_rd15: got %h want 1f", rd_data);
        end
        check_ram("good");
    endtask

    task automatic test_bad_checksum();
        set_counting();
        ck = 8'h00;
        // start from DONE with a coincident valid byte that must not be consumed
        run_load(0, -1, 1'b1);
        check_ram("bad");
    endtask

    task automatic test_toggle_valid();
        set_counting();
        ck = 8'h88;
        run_load(1, -1, 1'b0);
        check_ram("toggle");
    endtask

    task automatic test_mid_reset();
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 7; i++) begin
            in_valid = 1'b1;
            in_data  = 8'(8'hA0 + i);
            step();
            model_mem[i] = 8'(8'hA0 + i);
        end
        in_valid = 1'b0;
        rst = 1'b0;
        step();
        rst = 1'b1;
        checks++;
        if (in_ready !== 1'b0 || cpu_hold !== 1'b0 || done !== 1'b0 || err !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset: in_ready=%b cpu_hold=%b done=%b err=%b want 0 0 0 0",
                     in_ready, cpu_hold, done, err);
        end
        check_ram("mid_reset");
        for (int i = 0; i < 16; i++) stim[i] = 8'($urandom_range(0, 255));
        ck = 8'($urandom_range(0, 255));
        run_load(0, -1, 1'b0);
        check_ram("reload");
    endtask

    task automatic test_start_mid_load();
        for (int i = 0; i < 16; i++) stim[i] = 8'($urandom_range(0, 255));
        ck = 8'h00;
        for (int i = 0; i < 16; i++) ck = 8'(ck - stim[i]);
        run_load(2, 8, 1'b0);
        check_ram("start_mid");
    endtask

    task automatic test_random();
        int s;
        for (int n = 0; n < 4; n++) begin
            s = 0;
            for (int i = 0; i < 16; i++) begin
                stim[i] = 8'($urandom_range(0, 255));
                s += stim[i];
            end
            if ($urandom_range(0, 1) == 1) ck = 8'((256 - (s % 256)) % 256);
            else ck = 8'($urandom_range(0, 255));
            run_load(2, ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 16)) : -1, 1'($urandom_range(0, 1)));
            check_ram("random");
        end
    endtask

    initial begin
        rst      = 1'b0;
        start    = 1'b0;
        in_data  = 8'h00;
        in_valid = 1'b0;
        rd_addr  = 4'd0;
        for (int i = 0; i < 16; i++) begin
            model_mem[i]   = 8'h00;
            model_known[i] = 1'b0;
        end
        #1;
        test_reset();
        test_good_load();
        test_bad_checksum();
        test_toggle_valid();
        test_mid_reset();
        test_start_mid_load();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
